sequence_judge: RTL and testbench
=================================

Name: sequence_judge

Overview:
Parametrised two-player record/replay judge for the board game top level. It replaces the fixed P1/P2 FSM and the external 32x10 RAM with a single block. Player 1 records a sequence of up to DEPTH codes, each WIDTH bits wide. Player 2 replays the sequence, and the block scores each entry and reports the result. Inputs are single-cycle strobes in the `clock` domain; debounce and edge detection are done upstream.

Parameters:
WIDTH, 10, bit width of each code (switch/LED value).
DEPTH, 16, maximum sequence length; must be >= 2.
STRICT, 0, 1 = first player-2 mismatch ends the round immediately; 0 = player 2 always plays to the end.
CW (localparam), $clog2(DEPTH+1), width of the length, pointer and score counters.

Ports:
clock  in  1  system clock (CLOCK_50 domain).
resetn  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; begins a round from IDLE or RESULT.
next  in  1  one-cycle pulse; commit or judge `value_in`.
done  in  1  one-cycle pulse; ends the current player's turn.
value_in  in  WIDTH  code presented by the current player.
state  out  2  0=IDLE, 1=P1_ENTRY, 2=P2_ENTRY, 3=RESULT (drives HEX debug).
seq_len  out  CW  number of entries recorded by player 1.
index  out  CW  P1: write pointer; P2: read pointer.
full  out  1  high when seq_len == DEPTH in P1_ENTRY.
hits  out  CW  player-2 correct entries.
misses  out  CW  player-2 wrong or unanswered entries.
result_valid  out  1  high only in RESULT.
correct  out  1  in RESULT: hits == seq_len and seq_len != 0; otherwise 0.
last_value  out  WIDTH  most recently written (P1) or compared (P2) stored entry.

Behaviour:
- Reset (async, any state): state=IDLE; seq_len, index, hits, misses and last_value = 0; full, result_valid and correct = 0. Memory contents are don't-care.
- Storage: DEPTH x WIDTH register array, synchronously written. Reads are combinational at `index`.
- IDLE:
  - `start` -> P1_ENTRY; clear seq_len, index, hits and misses.
  - `next` and `done` are ignored.
- P1_ENTRY:
  - `next` with seq_len < DEPTH: mem[index] <= value_in; index++, seq_len++; last_value <= value_in. Takes effect on the next edge.
  - `next` when full: ignored, no wrap-around.
  - `done` with seq_len == 0 (after any same-cycle `next`): ignored.
  - `done` otherwise -> P2_ENTRY with index=0.
  - Same-cycle `next` and `done`: the write happens first, then the transition (one cycle).
- P2_ENTRY, on `next`:
  - Compare value_in with mem[index]. Equal -> hits++; not equal -> misses++.
  - last_value <= mem[index]; index++.
  - If index+1 == seq_len, go to RESULT.
  - If STRICT=1 and a mismatch occurs: misses += the remaining entries after this one, then go to RESULT.
- P2_ENTRY, on `done`:
  - misses += seq_len - index, evaluated after any same-cycle `next`, then go to RESULT.
  - Invariant in RESULT: hits + misses == seq_len.
- RESULT:
  - Counters are held.
  - `start` -> P1_ENTRY with a fresh round (counters cleared).
  - `next` and `done` are ignored.
- `start` in P1_ENTRY or P2_ENTRY is ignored. The only abort is reset.
- All transitions are registered, so outputs update one clock after the qualifying strobe.
- Counters never exceed DEPTH, so the CW width is sufficient.

Test Plan:
1. Reset: assert resetn=0 mid-P2 with hits=3 -> all outputs return to 0 and state=0 immediately, without waiting for a clock edge.
2. Perfect round, WIDTH=10, DEPTH=16, STRICT=0:
   - P1 records 0x155, 0x2AA, 0x3FF, then `done`.
   - P2 replays the same three codes.
   - Required: auto-transition to RESULT after the 3rd `next`; hits=3, misses=0, correct=1.
3. Partial and early done:
   - P1 records 4 codes. P2 gets entry 1 right and entry 2 wrong, then sends `done`.
   - Required: hits=1, misses=3, correct=0, state=3.
4. Full and empty boundaries:
   - 17 `next` pulses in P1 -> seq_len=16, full=1, entry 17 not written.
   - `done` with seq_len=0 -> state stays 1.
5. STRICT=1:
   - P1 records 5 codes. P2's 2nd entry is wrong.
   - Required: RESULT on that cycle with hits=1, misses=4.
6. Simultaneous strobes:
   - `next`+`done` in the same cycle in P1 with seq_len=0 -> entry stored, seq_len=1, state=2.
   - `next`+`done` in P2 at index 0 of 3 with a matching code -> hits=1, misses=2.

Source files
------------

// File: rtl/sequence_judge.sv
// sequence_judge: two-player record/replay judge with on-chip sequence storage.
// Ports: clock/resetn (async active-low); start/next/done single-cycle strobes;
// value_in code from the current player; state (0 IDLE,1 P1,2 P2,3 RESULT);
// seq_len recorded length; index write/read pointer; full when P1 storage is exhausted;
// hits/misses player-2 score; result_valid/correct round verdict; last_value
// most recently written or compared stored entry.
module sequence_judge #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16,
    parameter bit STRICT = 1'b0,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             next,
    input  logic             done,
    input  logic [WIDTH-1:0] value_in,
    output logic [1:0]       state,
    output logic [CW-1:0]    seq_len,
    output logic [CW-1:0]    index,
    output logic             full,
    output logic [CW-1:0]    hits,
    output logic [CW-1:0]    misses,
    output logic             result_valid,
    output logic             correct,
    output logic [WIDTH-1:0] last_value
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE = CW'(1);
    typedef enum logic [1:0] {IDLE, P1_ENTRY, P2_ENTRY, RESULT} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] seq_len_q, seq_len_d, index_q, index_d, hits_q, hits_d, misses_q, misses_d;
    logic [WIDTH-1:0] last_value_q, last_value_d;
    logic full_q, full_d, result_valid_q, result_valid_d, correct_q, correct_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_value;
    logic mem_we, hit, finish;
    assign rd_value = mem_q[index_q[AW-1:0]];
    always_comb begin
        state_d = state_q;
        seq_len_d = seq_len_q;
        index_d = index_q;
        hits_d = hits_q;
        misses_d = misses_q;
        last_value_d = last_value_q;
        mem_we = 1'b0;
        hit = value_in == rd_value;
        finish = 1'b0;
        case (state_q)
            IDLE, RESULT: begin
                if (start) begin
                    state_d = P1_ENTRY;
                    seq_len_d = '0;
                    index_d = '0;
                    hits_d = '0;
                    misses_d = '0;
                end
            end
            P1_ENTRY: begin
                mem_we = next && (seq_len_q < DEPTH_C);
                if (mem_we) begin
                    seq_len_d = seq_len_q + ONE;
                    index_d = index_q + ONE;
                    last_value_d = value_in;
                end
                // done is qualified on the post-write length so next+done on an empty record still advances
                if (done && seq_len_d != '0) begin
                    state_d = P2_ENTRY;
                    index_d = '0;
                end
            end
            P2_ENTRY: begin
                if (next) begin
                    hits_d = hits_q + CW'(hit);
                    misses_d = misses_q + CW'(!hit);
                    last_value_d = rd_value;
                    index_d = index_q + ONE;
                    finish = (index_d == seq_len_q) || (STRICT && !hit);
                end
                // every unplayed entry is charged as a miss exactly once when the round closes
                if (done || finish) begin
                    misses_d = misses_d + (seq_len_q - index_d);
                    state_d = RESULT;
                end
            end
        endcase
        full_d = (state_d == P1_ENTRY) && (seq_len_d == DEPTH_C);
        result_valid_d = state_d == RESULT;
        correct_d = result_valid_d && (hits_d == seq_len_d) && (seq_len_d != '0);
    end
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            seq_len_q <= '0;
            index_q <= '0;
            hits_q <= '0;
            misses_q <= '0;
            last_value_q <= '0;
            full_q <= 1'b0;
            result_valid_q <= 1'b0;
            correct_q <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_len_q <= seq_len_d;
            index_q <= index_d;
            hits_q <= hits_d;
            misses_q <= misses_d;
            last_value_q <= last_value_d;
            full_q <= full_d;
            result_valid_q <= result_valid_d;
            correct_q <= correct_d;
        end
    end
    always_ff @(posedge clock) begin
        if (mem_we) mem_q[index_q[AW-1:0]] <= value_in;
    end
    assign state = state_q;
    assign seq_len = seq_len_q;
    assign index = index_q;
    assign full = full_q;
    assign hits = hits_q;
    assign misses = misses_q;
    assign result_valid = result_valid_q;
    assign correct = correct_q;
    assign last_value = last_value_q;
endmodule

// File: tb/tb_sequence_judge.sv
// tb_sequence_judge: randomized self-checking bench for a lenient and a strict sequence_judge.
module tb_sequence_judge;
    logic clock = 1'b0, resetn = 1'b0, start = 1'b0, next = 1'b0, done = 1'b0;
    logic [9:0] value_in = '0;
    logic [1:0] state0, state1;
    logic [4:0] seq_len0, seq_len1, index0, index1, hits0, hits1, misses0, misses1;
    logic full0, full1, result_valid0, result_valid1, correct0, correct1;
    logic [9:0] last_value0, last_value1;
    int checks = 0, failures = 0;
    int m_state[2], m_len[2], m_idx[2], m_hits[2], m_miss[2], m_last[2];
    int m_mem[2][16];
    localparam int MATCH = -1, WRONG = -2, RND = -3;
    typedef struct {bit st; bit nx; bit dn; int v;} step_t;

    sequence_judge #(.WIDTH(10), .DEPTH(16), .STRICT(1'b0)) u_lenient (
        .clock(clock), .resetn(resetn), .start(start), .next(next), .done(done), .value_in(value_in),
        .state(state0), .seq_len(seq_len0), .index(index0), .full(full0), .hits(hits0), .misses(misses0),
        .result_valid(result_valid0), .correct(correct0), .last_value(last_value0));
    sequence_judge #(.WIDTH(10), .DEPTH(16), .STRICT(1'b1)) u_strict (
        .clock(clock), .resetn(resetn), .start(start), .next(next), .done(done), .value_in(value_in),
        .state(state1), .seq_len(seq_len1), .index(index1), .full(full1), .hits(hits1), .misses(misses1),
        .result_valid(result_valid1), .correct(correct1), .last_value(last_value1));

    always #5 clock = ~clock;

    function automatic logic [34:0] obs(int s);
        return (s == 0) ? {state0, seq_len0, index0, full0, hits0, misses0, result_valid0, correct0, last_value0}
                        : {state1, seq_len1, index1, full1, hits1, misses1, result_valid1, correct1, last_value1};
    endfunction

    function automatic logic [34:0] expv(int s);
        return {2'(m_state[s]), 5'(m_len[s]), 5'(m_idx[s]), 1'(m_state[s] == 1 && m_len[s] == 16),
                5'(m_hits[s]), 5'(m_miss[s]), 1'(m_state[s] == 3),
                1'(m_state[s] == 3 && m_hits[s] == m_len[s] && m_len[s] != 0), 10'(m_last[s])};
    endfunction

    function automatic step_t mk(bit st, bit nx, bit dn, int v);
        step_t p;
        p.st = st;
        p.nx = nx;
        p.dn = dn;
        p.v = v;
        return p;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_state[s] = 0; m_len[s] = 0; m_idx[s] = 0; m_hits[s] = 0; m_miss[s] = 0; m_last[s] = 0;
        end
    endtask

    // Scoring model: a closed round always charges misses as "length minus hits".
    task automatic model_step(int s, bit st, bit nx, bit dn, int v);
        bit fin, ok;
        case (m_state[s])
            0, 3: if (st) begin
                m_state[s] = 1; m_len[s] = 0; m_idx[s] = 0; m_hits[s] = 0; m_miss[s] = 0;
            end
            1: begin
                if (nx && m_len[s] < 16) begin
                    m_mem[s][m_len[s]] = v;
                    m_len[s]++;
                    m_last[s] = v;
                end
                m_idx[s] = m_len[s];
                if (dn && m_len[s] > 0) begin
                    m_state[s] = 2;
                    m_idx[s] = 0;
                end
            end
            default: begin
                fin = 1'b0;
                if (nx) begin
                    ok = v == m_mem[s][m_idx[s]];
                    if (ok) m_hits[s]++; else m_miss[s]++;
                    m_last[s] = m_mem[s][m_idx[s]];
                    m_idx[s]++;
                    fin = (m_idx[s] == m_len[s]) || (s == 1 && !ok);
                end
                if (dn || fin) begin
                    m_state[s] = 3;
                    m_miss[s] = m_len[s] - m_hits[s];
                end
            end
        endcase
    endtask

    task automatic cyc(step_t p);
        logic [9:0] v;
        if (p.v >= 0) v = 10'(p.v);
        else if (p.v != RND && m_state[0] == 2) v = 10'(m_mem[0][m_idx[0]] ^ ((p.v == WRONG) ? 1 : 0));
        else v = 10'($urandom);
        start = p.st; next = p.nx; done = p.dn; value_in = v;
        @(posedge clock);
        #1;
        for (int s = 0; s < 2; s++) model_step(s, p.st, p.nx, p.dn, int'(v));
        start = 1'b0; next = 1'b0; done = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (obs(s) !== 35'd0) begin
                failures++;
                $display("FAIL reset dut%0d got=%h exp=0", s, obs(s));
            end
        end
        model_reset();
        resetn = 1'b1;
    endtask

    task automatic test_perfect();
        step_t q[$];
        q = '{mk(1,0,0,RND), mk(0,1,0,'h155), mk(0,1,0,'h2AA), mk(0,1,0,'h3FF), mk(0,0,1,RND),
              mk(0,1,0,MATCH), mk(0,1,0,MATCH), mk(0,1,0,MATCH)};
        for (int i = 0; i < q.size(); i++) begin
            cyc(q[i]);
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (obs(s) !== expv(s)) begin
                    failures++;
                    $display("FAIL perfect step%0d dut%0d got=%h exp=%h", i, s, obs(s), expv(s));
                end
            end
        end
        checks++;
        if ({state0, hits0, misses0, correct0, last_value0} !== {2'd3, 5'd3, 5'd0, 1'b1, 10'h3FF}) begin
            failures++;
            $display("FAIL perfect_final got=%h exp=%h", {state0, hits0, misses0, correct0, last_value0},
                     {2'd3, 5'd3, 5'd0, 1'b1, 10'h3FF});
        end
    endtask

    task automatic test_partial();
        step_t q[$];
        q = '{mk(1,0,0,RND), mk(0,1,0,RND), mk(0,1,0,RND), mk(0,1,0,RND), mk(0,1,0,RND), mk(0,0,1,RND),
              mk(0,1,0,MATCH), mk(0,1,0,WRONG), mk(0,0,1,RND)};
        for (int i = 0; i < q.size(); i++) begin
            cyc(q[i]);
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (obs(s) !== expv(s)) begin
                    failures++;
                    $display("FAIL partial step%0d dut%0d got=%h exp=%h", i, s, obs(s), expv(s));
                end
            end
        end
        checks++;
        if ({state0, hits0, misses0, correct0} !== {2'd3, 5'd1, 5'd3, 1'b0}) begin
            failures++;
            $display("FAIL partial_final got=%h exp=%h", {state0, hits0, misses0, correct0}, {2'd3, 5'd1, 5'd3, 1'b0});
        end
    endtask

    task automatic test_boundaries();
        step_t q[$];
        q.push_back(mk(1,0,0,RND));
        q.push_back(mk(0,0,1,RND));
        for (int i = 0; i < 17; i++) q.push_back(mk(0,1,0,RND));
        q.push_back(mk(0,0,1,RND));
        for (int i = 0; i < 16; i++) q.push_back(mk(0,1,0,MATCH));
        for (int i = 0; i < q.size(); i++) begin
            cyc(q[i]);
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (obs(s) !== expv(s)) begin
                    failures++;
                    $display("FAIL boundary step%0d dut%0d got=%h exp=%h", i, s, obs(s), expv(s));
                end
            end
            if (i == 1) begin
                checks++;
                if (state0 !== 2'd1) begin
                    failures++;
                    $display("FAIL empty_done state got=%0d exp=1", state0);
                end
            end
            if (i == 18) begin
                checks++;
                if ({seq_len0, index0, full0} !== {5'd16, 5'd16, 1'b1}) begin
                    failures++;
                    $display("FAIL full got len=%0d idx=%0d full=%0d exp 16 16 1", seq_len0, index0, full0);
                end
            end
        end
        checks++;
        if ({state0, hits0, misses0, correct0} !== {2'd3, 5'd16, 5'd0, 1'b1}) begin
            failures++;
            $display("FAIL full_replay got=%h exp=%h", {state0, hits0, misses0, correct0}, {2'd3, 5'd16, 5'd0, 1'b1});
        end
    endtask

    task automatic test_strict();
        step_t q[$];
        q = '{mk(1,0,0,RND), mk(0,1,0,RND), mk(0,1,0,RND), mk(0,1,0,RND), mk(0,1,0,RND), mk(0,1,0,RND),
              mk(0,0,1,RND), mk(0,1,0,MATCH), mk(0,1,0,WRONG), mk(0,0,1,RND)};
        for (int i = 0; i < q.size(); i++) begin
            cyc(q[i]);
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (obs(s) !== expv(s)) begin
                    failures++;
                    $display("FAIL strict step%0d dut%0d got=%h exp=%h", i, s, obs(s), expv(s));
                end
            end
            if (i == 8) begin
                checks++;
                if ({state1, hits1, misses1, state0} !== {2'd3, 5'd1, 5'd4, 2'd2}) begin
                    failures++;
                    $display("FAIL strict_stop got=%h exp=%h", {state1, hits1, misses1, state0}, {2'd3, 5'd1, 5'd4, 2'd2});
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        step_t q[$];
        q = '{mk(1,0,0,RND), mk(0,1,1,RND), mk(0,1,0,MATCH), mk(1,0,0,RND), mk(1,1,0,RND), mk(0,1,0,RND),
              mk(0,1,1,RND), mk(0,1,1,MATCH)};
        for (int i = 0; i < q.size(); i++) begin
            cyc(q[i]);
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (obs(s) !== expv(s)) begin
                    failures++;
                    $display("FAIL simul step%0d dut%0d got=%h exp=%h", i, s, obs(s), expv(s));
                end
            end
            if (i == 1) begin
                checks++;
                if ({seq_len0, state0} !== {5'd1, 2'd2}) begin
                    failures++;
                    $display("FAIL simul_p1 got len=%0d state=%0d exp 1 2", seq_len0, state0);
                end
            end
        end
        checks++;
        if ({state0, hits0, misses0} !== {2'd3, 5'd1, 5'd2}) begin
            failures++;
            $display("FAIL simul_p2 got=%h exp=%h", {state0, hits0, misses0}, {2'd3, 5'd1, 5'd2});
        end
    endtask

    task automatic test_async_reset();
        step_t q[$];
        q = '{mk(1,0,0,RND), mk(0,1,0,RND), mk(0,1,0,RND), mk(0,1,0,RND), mk(0,1,0,RND), mk(0,1,0,RND),
              mk(0,0,1,RND), mk(0,1,0,MATCH), mk(0,1,0,MATCH), mk(0,1,0,MATCH)};
        for (int i = 0; i < q.size(); i++) begin
            cyc(q[i]);
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (obs(s) !== expv(s)) begin
                    failures++;
                    $display("FAIL pre_reset step%0d dut%0d got=%h exp=%h", i, s, obs(s), expv(s));
                end
            end
        end
        #2;
        resetn = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (obs(s) !== 35'd0) begin
                failures++;
                $display("FAIL async_reset dut%0d got=%h exp=0", s, obs(s));
            end
        end
        model_reset();
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_random();
        step_t p;
        for (int i = 0; i < 800; i++) begin
            p = mk($urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 11) == 0,
                   ($urandom_range(0, 2) == 0) ? RND : MATCH);
            cyc(p);
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (obs(s) !== expv(s)) begin
                    failures++;
                    $display("FAIL random cyc%0d dut%0d got=%h exp=%h", i, s, obs(s), expv(s));
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_perfect();
        test_partial();
        test_boundaries();
        test_strict();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
